// File: rtl/c_mem_drain_pkg.sv
// Shared constants and the FSM state type for the C-memory drain stage.
//   C_DEPTH : number of C words drained per run
//   C_DW    : C word width
//   C_AW    : word index width (row = index[AW-1:2], column = index[1:0])
//   C_CSW   : checksum width, wide enough for DEPTH words of DW bits
package c_mem_drain_pkg;

  localparam int unsigned C_DEPTH = 1024;
  localparam int unsigned C_DW    = 21;
  localparam int unsigned C_AW    = 10;
  localparam int unsigned C_CSW   = C_DW + C_AW;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/c_drain_fifo.sv
// Two-entry first-in first-out buffer holding a C word plus its index.
// It absorbs the one-cycle read latency of the C memory.
//   clk, rst        : clock, asynchronous active-high reset
//   push_i          : write push_data_i/push_index_i at end of cycle
//   pop_i           : discard the head entry at end of cycle
//   count_o         : number of valid entries (0..2)
//   head_data_o     : data of the oldest entry
//   head_index_o    : index of the oldest entry
module c_drain_fifo
  import c_mem_drain_pkg::*;
#(
  parameter int unsigned DW = C_DW,
  parameter int unsigned AW = C_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic [AW-1:0] push_index_i,
  input  logic          pop_i,
  output logic [1:0]    count_o,
  output logic [DW-1:0] head_data_o,
  output logic [AW-1:0] head_index_o
);

  logic [DW-1:0] data_q  [2];
  logic [AW-1:0] index_q [2];
  logic          wr_ptr_q;
  logic          rd_ptr_q;
  logic [1:0]    count_q;
  logic [1:0]    count_d;

  // Occupancy update; simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Storage and pointers; entries clear on reset so the head reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        data_q[i]  <= '0;
        index_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      count_q <= count_d;
      if (push_i) begin
        data_q[wr_ptr_q]  <= push_data_i;
        index_q[wr_ptr_q] <= push_index_i;
        wr_ptr_q          <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  assign count_o      = count_q;
  assign head_data_o  = data_q[rd_ptr_q];
  assign head_index_o = index_q[rd_ptr_q];

endmodule

// File: rtl/c_mem_drain.sv
// Drains every word of the C result memory after a start pulse and streams
// them out on a valid/ready interface with index, last flag and checksum.
//   clk, rst          : clock, asynchronous active-high reset
//   start             : begin a drain (only honoured in IDLE)
//   busy              : high outside IDLE
//   finished          : one-cycle pulse after the last word is accepted
//   checksum          : sum of accepted words, cleared on start
//   mem_ra/mem_ca     : C memory row/column address
//   mem_nce, mem_nwrt : active-low chip enable (read issue), write disable
//   mem_do            : C memory read data, valid the cycle after issue
//   out_data/out_index/out_last/out_valid/out_ready : output stream
module c_mem_drain
  import c_mem_drain_pkg::*;
#(
  parameter int unsigned DEPTH = C_DEPTH,
  parameter int unsigned DW    = C_DW,
  parameter int unsigned AW    = C_AW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             finished,
  output logic [DW+AW-1:0] checksum,
  output logic [AW-3:0]    mem_ra,
  output logic [1:0]       mem_ca,
  output logic             mem_nce,
  output logic             mem_nwrt,
  input  logic [DW-1:0]    mem_do,
  output logic [DW-1:0]    out_data,
  output logic [AW-1:0]    out_index,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned CSW = DW + AW;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_e         state_q;
  state_e         state_d;
  logic [AW-1:0]  addr_q;
  logic           inflight_q;
  logic [AW-1:0]  inflight_idx_q;
  logic [CSW-1:0] checksum_q;
  logic           finished_q;

  logic [1:0]     fifo_count;
  logic [DW-1:0]  head_data;
  logic [AW-1:0]  head_index;
  logic [2:0]     occupancy;
  logic           pop;
  logic           issue_c;
  logic           busy_c;

  assign out_valid = (fifo_count != 2'd0);
  assign pop       = out_valid & out_ready;
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_READ;
      ST_READ:  if (issue_c && (addr_q == LAST_IDX)) state_d = ST_DRAIN;
      ST_DRAIN: if (pop && out_last) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output logic: a read may issue while buffer + in-flight slot has room,
  // counting a same-cycle pop as freeing one entry.
  always_comb begin
    issue_c = 1'b0;
    busy_c  = (state_q != ST_IDLE);
    if (state_q == ST_READ) begin
      issue_c = (occupancy < 3'd2) || ((occupancy == 3'd2) && pop);
    end
  end

  // Issue counter, in-flight tracking, checksum and finished pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q         <= '0;
      inflight_q     <= 1'b0;
      inflight_idx_q <= '0;
      checksum_q     <= '0;
      finished_q     <= 1'b0;
    end else begin
      inflight_q <= issue_c;
      finished_q <= pop & out_last;
      if (issue_c) begin
        inflight_idx_q <= addr_q;
      end
      // Counter stops at the last address instead of wrapping.
      if ((state_q == ST_IDLE) && start) begin
        addr_q <= '0;
      end else if (issue_c && (addr_q != LAST_IDX)) begin
        addr_q <= addr_q + AW'(1);
      end
      if ((state_q == ST_IDLE) && start) begin
        checksum_q <= '0;
      end else if (pop) begin
        checksum_q <= checksum_q + CSW'(head_data);
      end
    end
  end

  // Read data lands in the buffer one cycle after its issue.
  c_drain_fifo #(
    .DW(DW),
    .AW(AW)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_data_i (mem_do),
    .push_index_i(inflight_idx_q),
    .pop_i       (pop),
    .count_o     (fifo_count),
    .head_data_o (head_data),
    .head_index_o(head_index)
  );

  assign busy      = busy_c;
  assign finished  = finished_q;
  assign checksum  = checksum_q;
  assign mem_ra    = addr_q[AW-1:2];
  assign mem_ca    = addr_q[1:0];
  assign mem_nce   = ~issue_c;
  assign mem_nwrt  = 1'b1;
  assign out_data  = head_data;
  assign out_index = head_index;
  assign out_last  = out_valid && (head_index == LAST_IDX);

endmodule

// File: tb/tb_c_mem_drain.sv
// Bench for c_mem_drain: memory model, randomized out_ready, and a
// stream-level reference model checked every cycle.
module tb_c_mem_drain;

  localparam int DEPTH = 1024;
  localparam int DW    = 21;
  localparam int AW    = 10;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             busy;
  logic             finished;
  logic [DW+AW-1:0] checksum;
  logic [AW-3:0]    mem_ra;
  logic [1:0]       mem_ca;
  logic             mem_nce;
  logic             mem_nwrt;
  logic [DW-1:0]    mem_do = '0;
  logic [DW-1:0]    out_data;
  logic [AW-1:0]    out_index;
  logic             out_last;
  logic             out_valid;
  logic             out_ready = 1'b1;

  c_mem_drain dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .finished(finished),
    .checksum(checksum), .mem_ra(mem_ra), .mem_ca(mem_ca), .mem_nce(mem_nce),
    .mem_nwrt(mem_nwrt), .mem_do(mem_do), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] words [DEPTH];

  // Synchronous-read memory: data appears the cycle after a read issue.
  always @(posedge clk) begin
    if (!mem_nce) mem_do <= words[{mem_ra, mem_ca}];
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model state.
  int     exp_idx, issued, accepted, fin_count, first_valid, fin_cycle;
  longint model_sum;
  bit     fin_exp, hold_prev;
  int     t0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    exp_idx = 0; issued = 0; accepted = 0; fin_count = 0;
    first_valid = -1; fin_cycle = -1; model_sum = 0;
    fin_exp = 0; hold_prev = 0;
  endtask

  // Per-cycle comparison against the stream model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("finished", longint'(finished), longint'(fin_exp));
      fin_exp = 0;
      if (finished) begin
        fin_count++;
        fin_cycle = cyc;
        chk("checksum_at_finish", longint'(checksum), model_sum);
        chk("busy_at_finish", longint'(busy), 0);
      end
      chk("mem_nwrt", longint'(mem_nwrt), 1);
      if (!mem_nce) begin
        if (issued >= DEPTH) chk("extra_issue", issued, DEPTH - 1);
        else chk("issue_addr", longint'({mem_ra, mem_ca}), issued);
        issued++;
      end
      if (hold_prev) chk("valid_held", longint'(out_valid), 1);
      if (out_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (exp_idx >= DEPTH) begin
          chk("extra_word", exp_idx, DEPTH - 1);
        end else begin
          chk("out_index", longint'(out_index), exp_idx);
          chk("out_data", longint'(out_data), longint'(words[exp_idx]));
          chk("out_last", longint'(out_last), longint'(exp_idx == DEPTH - 1));
          if (out_ready) begin
            model_sum += longint'(words[exp_idx]);
            if (exp_idx == DEPTH - 1) fin_exp = 1;
            exp_idx++;
            accepted++;
          end
        end
      end else begin
        chk("out_last_idle", longint'(out_last), 0);
      end
      hold_prev = out_valid && !out_ready;
      chk("outstanding_le2", longint'((issued - accepted) <= 2), 1);
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, longint'(busy), 0);
    chk({tag, "_finished"}, longint'(finished), 0);
    chk({tag, "_out_valid"}, longint'(out_valid), 0);
    chk({tag, "_out_last"}, longint'(out_last), 0);
    chk({tag, "_out_data"}, longint'(out_data), 0);
    chk({tag, "_out_index"}, longint'(out_index), 0);
    chk({tag, "_checksum"}, longint'(checksum), 0);
    chk({tag, "_mem_nce"}, longint'(mem_nce), 1);
    chk({tag, "_mem_addr"}, longint'({mem_ra, mem_ca}), 0);
    chk({tag, "_mem_nwrt"}, longint'(mem_nwrt), 1);
  endtask

  // mode 0: ready high, 1: random 50%, 2: ready low for cycles 3..22.
  task automatic run_drain(input int mode, input int restart_at, input int abort_at);
    int k;
    bit done;
    model_reset();
    @(posedge clk); #1;
    start = 1'b1;
    out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    t0 = cyc;
    k = 0;
    done = 0;
    while (!done) begin
      @(posedge clk); #1;
      k = cyc - t0;
      start = (restart_at > 0) && (k == restart_at);
      if (mode == 1) out_ready = 1'($urandom_range(0, 1));
      else if (mode == 2) begin
        if (k == 23) chk("issues_during_stall", issued, 2);
        out_ready = !(k >= 3 && k < 23);
      end else out_ready = 1'b1;
      if (abort_at > 0 && issued > abort_at) done = 1;
      if (fin_count > 0) done = 1;
      if (k > 6000) begin
        chk("drain_timeout", 0, 1);
        done = 1;
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
    if (abort_at == 0) begin
      repeat (3) @(posedge clk);
      #1;
      chk("finished_pulses", fin_count, 1);
      chk("words_accepted", exp_idx, DEPTH);
      chk("busy_after", longint'(busy), 0);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) words[i] = DW'(i & 32'h1FFFFF);
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("por");
    @(negedge clk) rst = 1'b0;

    // Ramp data, ready always high: exact timing and checksum.
    run_drain(0, 0, 0);
    chk("first_valid_cycle", first_valid - t0, 3);
    chk("finished_cycle", fin_cycle - t0, 1027);
    chk("ramp_checksum", longint'(checksum), 523776);

    // Random backpressure.
    run_drain(1, 0, 0);
    chk("random_checksum", longint'(checksum), 523776);

    // Long stall right after the first valid word.
    run_drain(2, 0, 0);
    chk("stall_checksum", longint'(checksum), 523776);

    // Start pulse while busy must be ignored.
    run_drain(0, 500, 0);
    chk("restart_checksum", longint'(checksum), 523776);

    // Asynchronous reset mid-read, then a fresh drain.
    run_drain(0, 0, 300);
    @(posedge clk); #2;
    rst = 1'b1;
    #1 check_reset_outputs("mid_rst");
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk) rst = 1'b0;
    run_drain(0, 0, 0);
    chk("after_rst_first_valid", first_valid - t0, 3);
    chk("after_rst_checksum", longint'(checksum), 523776);

    // All-ones data: full-width checksum.
    for (int i = 0; i < DEPTH; i++) words[i] = 21'h1FFFFF;
    run_drain(1, 0, 0);
    chk("ones_checksum", longint'(checksum), 64'd2147482624);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
